// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle fetch/decode/exec/writeback sequencer owning PC and IR; optional FETCH_SEQ_SINGLE_STEP_EN
module fetch_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int RESET_PC    = 0,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [16:0]       imem_rdata,
  output logic [16:0]       ir,
  output logic              ir_valid,
  input  logic [1:0]        bs,
  input  logic              ps,
  input  logic              mw,
  input  logic [1:0]        md,
  input  logic              rw,
  input  logic              z_flag,
  input  logic [ADDR_W-1:0] bus_a,
  input  logic [ADDR_W-1:0] br_off,
  output logic              dmem_req,
  input  logic              dmem_ack,
  output logic              rw_en,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              fault
);

  localparam int                CNT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam logic [ADDR_W-1:0] RESET_PC_V  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE      = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_tgt;
  logic [ADDR_W-1:0] pc_tgt_q;
  logic [16:0]       ir_q;
  logic [CNT_W-1:0]  wait_q;
  logic              mem_op;
  logic              timed_out;

  assign mem_op    = mw | (md == 2'b01);
  assign timed_out = (wait_q == TIMEOUT_CNT);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign fault     = (state_q == S_FAULT);

  // Next-instruction address from the decoder's branch controls, captured when EXEC ends
  always_comb begin
    pc_tgt = pc_q + PC_ONE;
    case (bs)
      2'b00: pc_tgt = pc_q + PC_ONE;
      2'b01: pc_tgt = (z_flag ^ ps) ? (pc_q + br_off) : (pc_q + PC_ONE);
      2'b10: pc_tgt = bus_a;
      2'b11: pc_tgt = pc_q + br_off;
      default: pc_tgt = pc_q + PC_ONE;
    endcase
  end

  // Sequencer next state and per-state request/strobe outputs
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_valid = 1'b0;
    rw_en    = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)       state_d = S_DECODE;
        else if (timed_out) state_d = S_FAULT;
      end
      S_DECODE: begin
        ir_valid = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        ir_valid = 1'b1;
        if (mem_op) begin
          dmem_req = 1'b1;
          if (dmem_ack)       state_d = S_WB;
          else if (timed_out) state_d = S_FAULT;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        ir_valid = 1'b1;
        rw_en    = rw;
        retire   = 1'b1;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
        state_d  = S_HOLD;
`else
        state_d  = S_FETCH;
`endif
      end
      S_HOLD: begin
`ifdef FETCH_SEQ_SINGLE_STEP_EN
        if (step) state_d = S_FETCH;
`else
        state_d = S_FETCH;
`endif
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // PC, IR, branch target latch and memory wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC_V;
      pc_tgt_q <= '0;
      ir_q     <= '0;
      wait_q   <= '0;
    end else begin
      if (state_q == S_FETCH && imem_ack)
        ir_q <= imem_rdata;
      if (state_q == S_EXEC && state_d == S_WB)
        pc_tgt_q <= pc_tgt;
      if (state_q == S_WB)
        pc_q <= pc_tgt_q;
      if (state_d != state_q)
        wait_q <= '0;
      else if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack))
        wait_q <= wait_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - cycle-accurate timeline model bench for fetch_sequencer
module tb_fetch_sequencer;

  localparam int AW  = 8;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [16:0]   imem_rdata;
  logic [16:0]   ir;
  logic          ir_valid;
  logic [1:0]    bs;
  logic          ps;
  logic          mw;
  logic [1:0]    md;
  logic          rw;
  logic          z_flag;
  logic [AW-1:0] bus_a;
  logic [AW-1:0] br_off;
  logic          dmem_req;
  logic          dmem_ack;
  logic          rw_en;
  logic [AW-1:0] pc;
  logic          retire;
  logic          fault;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(AW), .RESET_PC(0), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .ir_valid(ir_valid),
    .bs(bs), .ps(ps), .mw(mw), .md(md), .rw(rw), .z_flag(z_flag),
    .bus_a(bus_a), .br_off(br_off),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .rw_en(rw_en), .pc(pc), .retire(retire), .fault(fault)
  );

  typedef struct {
    logic          rst;
    logic          imem_ack;
    logic [16:0]   rdata;
    logic [1:0]    bs;
    logic          ps;
    logic          mw;
    logic [1:0]    md;
    logic          rw;
    logic          z;
    logic [AW-1:0] bus_a;
    logic [AW-1:0] br_off;
    logic          dmem_ack;
  } stim_t;

  typedef struct {
    bit            chk;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [16:0]   ir;
    logic          ir_valid;
    logic          dmem_req;
    logic          rw_en;
    logic [AW-1:0] pc;
    logic          retire;
    logic          fault;
  } exp_t;

  stim_t         sq[$];
  exp_t          eq[$];
  stim_t         cur_s;
  exp_t          cur_e;
  logic [AW-1:0] m_pc;
  logic [16:0]   m_ir;
  int            tests = 0;
  int            fails = 0;
  int            cur_idx = 0;
  bit            active = 1'b0;

  // Architectural next-PC rule, plain modulo-256 arithmetic
  function automatic logic [AW-1:0] next_pc(input logic [AW-1:0] p, input logic [1:0] b,
                                            input logic pol, input logic z, input logic [AW-1:0] a,
                                            input logic [AW-1:0] off);
    case (b)
      2'd0:    return p + 8'd1;
      2'd1:    return ((z ^ pol) != 1'b0) ? p + off : p + 8'd1;
      2'd2:    return a;
      default: return p + off;
    endcase
  endfunction

  task automatic clr_s();
    cur_s.rst      = 1'b0;
    cur_s.imem_ack = 1'b0;
    cur_s.rdata    = 17'h0;
    cur_s.dmem_ack = 1'b0;
  endtask

  task automatic clr_e();
    cur_e.chk       = 1'b1;
    cur_e.imem_req  = 1'b0;
    cur_e.imem_addr = m_pc;
    cur_e.ir        = m_ir;
    cur_e.ir_valid  = 1'b0;
    cur_e.dmem_req  = 1'b0;
    cur_e.rw_en     = 1'b0;
    cur_e.pc        = m_pc;
    cur_e.retire    = 1'b0;
    cur_e.fault     = 1'b0;
  endtask

  task automatic push();
    sq.push_back(cur_s);
    eq.push_back(cur_e);
  endtask

  task automatic reset_tail();
    m_pc = 8'h00;
    m_ir = 17'h0;
    clr_s(); cur_s.rst = 1'b1; clr_e(); push();
    clr_s(); clr_e(); push();
  endtask

  task automatic pin(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: model pc=%02h required=%02h", name, act, req);
    end
  endtask

  // One instruction: fetch with idly ack-less cycles, decode, exec (optionally a data access), writeback
  task automatic instr(input logic [16:0] w, input int idly, input logic mw_i, input logic [1:0] md_i,
                       input int ddly, input logic [1:0] bs_i, input logic ps_i, input logic z_i,
                       input logic rw_i, input logic [AW-1:0] a_i, input logic [AW-1:0] off_i,
                       input bit noise, input int abort_k);
    bit mem;
    mem = (mw_i == 1'b1) || (md_i == 2'b01);
    cur_s.bs = bs_i; cur_s.ps = ps_i; cur_s.mw = mw_i; cur_s.md = md_i;
    cur_s.rw = rw_i; cur_s.z = z_i; cur_s.bus_a = a_i; cur_s.br_off = off_i;
    for (int k = 0; k <= idly; k++) begin
      clr_s(); cur_s.imem_ack = (k == idly); cur_s.rdata = w;
      clr_e(); cur_e.imem_req = 1'b1; push();
    end
    m_ir = w;
    clr_s(); cur_s.rdata = 17'h1FFFF;
    if (noise) begin cur_s.imem_ack = 1'b1; cur_s.dmem_ack = 1'b1; end
    clr_e(); cur_e.ir_valid = 1'b1; push();
    if (mem) begin
      for (int k = 0; k <= ddly; k++) begin
        clr_s(); cur_s.dmem_ack = (k == ddly); cur_s.imem_ack = noise;
        if (abort_k == k) begin cur_s.dmem_ack = 1'b0; cur_s.rst = 1'b1; end
        clr_e(); cur_e.ir_valid = 1'b1; cur_e.dmem_req = 1'b1; push();
        if (abort_k == k) begin reset_tail(); return; end
      end
    end else begin
      clr_s(); cur_s.imem_ack = noise; cur_s.dmem_ack = noise;
      clr_e(); cur_e.ir_valid = 1'b1; push();
    end
    clr_s(); cur_s.imem_ack = noise; cur_s.dmem_ack = noise;
    clr_e(); cur_e.ir_valid = 1'b1; cur_e.rw_en = rw_i; cur_e.retire = 1'b1; push();
    m_pc = next_pc(m_pc, bs_i, ps_i, z_i, a_i, off_i);
  endtask

  // Fetch never acknowledged: TMO+1 request cycles, then sticky fault until reset
  task automatic fault_fetch();
    for (int k = 0; k <= TMO; k++) begin
      clr_s(); clr_e(); cur_e.imem_req = 1'b1; push();
    end
    for (int j = 0; j < 3; j++) begin
      clr_s(); cur_s.imem_ack = (j == 1); cur_s.rst = (j == 2);
      clr_e(); cur_e.fault = 1'b1; push();
    end
    reset_tail();
  endtask

  task automatic build();
    m_pc = 8'h00; m_ir = 17'h0;
    cur_s.bs = 2'b00; cur_s.ps = 1'b0; cur_s.mw = 1'b0; cur_s.md = 2'b00;
    cur_s.rw = 1'b0; cur_s.z = 1'b0; cur_s.bus_a = 8'h00; cur_s.br_off = 8'h00;
    clr_s(); cur_s.rst = 1'b1; clr_e(); cur_e.chk = 1'b0; push();
    reset_tail();
    instr(17'h0A123, 1, 1'b0, 2'b00, 0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, -1);
    pin("add_pc", m_pc, 8'h01);
    instr(17'h1B004, 0, 1'b0, 2'b01, 3, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, -1);
    pin("ld_pc", m_pc, 8'h02);
    instr(17'h05A5A, 0, 1'b1, 2'b00, 0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, -1);
    instr(17'h13C3C, 0, 1'b0, 2'b10, 0, 2'b10, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, -1);
    pin("jmp_pc", m_pc, 8'h10);
    instr(17'h0F00F, 0, 1'b0, 2'b00, 0, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFC, 1'b0, -1);
    pin("brz_taken", m_pc, 8'h0C);
    instr(17'h13C3C, 0, 1'b0, 2'b00, 0, 2'b10, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, -1);
    instr(17'h0F00F, 0, 1'b0, 2'b00, 0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFC, 1'b0, -1);
    pin("brz_not_taken", m_pc, 8'h11);
    instr(17'h0F10F, 2, 1'b0, 2'b00, 0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 8'h05, 1'b0, -1);
    pin("brnz_taken", m_pc, 8'h16);
    instr(17'h1E0E9, 0, 1'b0, 2'b00, 0, 2'b11, 1'b0, 1'b0, 1'b1, 8'h00, 8'hE9, 1'b0, -1);
    pin("bra_back", m_pc, 8'hFF);
    instr(17'h00001, 0, 1'b0, 2'b00, 0, 2'b00, 1'b0, 1'b1, 1'b1, 8'h77, 8'h33, 1'b1, -1);
    pin("wrap_pc", m_pc, 8'h00);
    instr(17'h1FFFE, TMO, 1'b0, 2'b00, 0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, -1);
    pin("late_ack_pc", m_pc, 8'h01);
    instr(17'h1B008, 0, 1'b0, 2'b01, 6, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 2);
    pin("abort_pc", m_pc, 8'h00);
    instr(17'h0A456, 0, 1'b0, 2'b00, 0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, -1);
    fault_fetch();
    instr(17'h0A789, 2, 1'b0, 2'b00, 0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, -1);
    pin("recover_pc", m_pc, 8'h01);
  endtask

  task automatic apply(input stim_t s);
    rst        = s.rst;
    imem_ack   = s.imem_ack;
    imem_rdata = s.rdata;
    bs         = s.bs;
    ps         = s.ps;
    mw         = s.mw;
    md         = s.md;
    rw         = s.rw;
    z_flag     = s.z;
    bus_a      = s.bus_a;
    br_off     = s.br_off;
    dmem_ack   = s.dmem_ack;
  endtask

  // Compare every checked cycle against the timeline model
  always @(negedge clk) begin
    if (active && eq[cur_idx].chk) begin
      tests++;
      if ({imem_req, imem_addr, ir, ir_valid, dmem_req, rw_en, pc, retire, fault} !==
          {eq[cur_idx].imem_req, eq[cur_idx].imem_addr, eq[cur_idx].ir, eq[cur_idx].ir_valid,
           eq[cur_idx].dmem_req, eq[cur_idx].rw_en, eq[cur_idx].pc, eq[cur_idx].retire,
           eq[cur_idx].fault}) begin
        fails++;
        $display("FAIL cyc%0d: got ireq=%b addr=%02h ir=%05h irv=%b dreq=%b rwen=%b pc=%02h ret=%b flt=%b want ireq=%b addr=%02h ir=%05h irv=%b dreq=%b rwen=%b pc=%02h ret=%b flt=%b",
                 cur_idx, imem_req, imem_addr, ir, ir_valid, dmem_req, rw_en, pc, retire, fault,
                 eq[cur_idx].imem_req, eq[cur_idx].imem_addr, eq[cur_idx].ir, eq[cur_idx].ir_valid,
                 eq[cur_idx].dmem_req, eq[cur_idx].rw_en, eq[cur_idx].pc, eq[cur_idx].retire,
                 eq[cur_idx].fault);
      end
    end
  end

  // Drive the prebuilt stimulus one cycle at a time
  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 17'h0; bs = 2'b00; ps = 1'b0; mw = 1'b0;
    md = 2'b00; rw = 1'b0; z_flag = 1'b0; bus_a = 8'h00; br_off = 8'h00; dmem_ack = 1'b0;
    build();
    for (int c = 0; c < sq.size(); c++) begin
      @(posedge clk);
      #1;
      apply(sq[c]);
      cur_idx = c;
      active  = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    active = 1'b0;
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
